// File: rtl/median_checker_if.sv
// Pattern-word handshake between a pattern source and median_checker.
//   pat_valid : source has a pattern word available
//   pat_ready : checker can accept a pattern word
//   pat_data  : {a0[31:24], a1[23:16], a2[15:8], expected[7:0]}
//   pat_last  : marks the final pattern word of a run
interface median_checker_if;
    logic        pat_valid;
    logic        pat_ready;
    logic [31:0] pat_data;
    logic        pat_last;

    modport master (
        output pat_valid,
        output pat_data,
        output pat_last,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  pat_last,
        output pat_ready
    );
endinterface

// File: rtl/median_checker.sv
// median_checker: applies pattern operands to an external 3-input median
// block, waits SETTLE_CYC cycles, compares the result with the expected
// value carried in the pattern word and keeps saturating pass/fail tallies.
//   clk, rst          : clock, asynchronous active-high reset
//   clr               : synchronous clear of tallies/error state, back to IDLE
//   pat (slave)       : pattern-word handshake (valid/ready/data/last)
//   a0, a1, a2        : registered operands to the median block
//   med_out           : median block result (combinational on a0..a2)
//   pass_cnt/fail_cnt : saturating compare tallies
//   err_valid         : one-cycle pulse after a mismatching compare
//   err_exp/err_got   : expected/actual of the most recent mismatch
//   done              : high once the last pattern has been checked
module median_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    median_checker_if.slave      pat,
    output logic [7:0]           a0,
    output logic [7:0]           a1,
    output logic [7:0]           a2,
    input  logic [7:0]           med_out,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 err_valid,
    output logic [7:0]           err_exp,
    output logic [7:0]           err_got,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(SETTLE_CYC - 1);

    state_t           r_state;
    logic             r_ready;
    logic [7:0]       r_a0, r_a1, r_a2;
    logic [7:0]       r_exp;
    logic             r_last;
    logic [7:0]       r_hold;
    logic [CNT_W-1:0] r_pass, r_fail;
    logic             r_err_valid;
    logic [7:0]       r_err_exp, r_err_got;
    logic             r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_a0        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_exp       <= '0;
            r_last      <= 1'b0;
            r_hold      <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_err_valid <= 1'b0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_done      <= 1'b0;
        end else if (clr) begin
            // Operands are deliberately left as they are; a pattern offered
            // in this cycle is dropped.
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_pass      <= '0;
            r_fail      <= '0;
            r_err_valid <= 1'b0;
            r_err_exp   <= '0;
            r_err_got   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // pat_ready is 1 throughout IDLE, so valid alone is a transfer.
                    if (pat.pat_valid) begin
                        r_a0    <= pat.pat_data[31:24];
                        r_a1    <= pat.pat_data[23:16];
                        r_a2    <= pat.pat_data[15:8];
                        r_exp   <= pat.pat_data[7:0];
                        r_last  <= pat.pat_last;
                        r_hold  <= HOLD_LOAD;
                        r_ready <= 1'b0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= CHECK;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end
                CHECK: begin
                    if (med_out == r_exp) begin
                        if (r_pass != '1) r_pass <= r_pass + 1'b1;
                    end else begin
                        if (r_fail != '1) r_fail <= r_fail + 1'b1;
                        r_err_exp   <= r_exp;
                        r_err_got   <= med_out;
                        r_err_valid <= 1'b1;
                    end
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    // Parked until clr or rst.
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pat.pat_ready = r_ready;
    assign a0            = r_a0;
    assign a1            = r_a1;
    assign a2            = r_a2;
    assign pass_cnt      = r_pass;
    assign fail_cnt      = r_fail;
    assign err_valid     = r_err_valid;
    assign err_exp       = r_err_exp;
    assign err_got       = r_err_got;
    assign done          = r_done;

endmodule
